// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline stall/flush sequencer and its
//   helpers:
//     XZR_IDX  - index of the zero register. It is never a real producer,
//                so it never creates a dependency.
//     state_e  - sequencer state (RUN / LU_STALL).
//     ctrl_t   - bundle of pipeline-register controls, in the order
//                {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble,
//                ex_mem_we}.
//   The package also holds the canonical control bundles for each
//   situation the sequencer can be in.
package pipe_ctrl_pkg;

  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_bubble;
    logic ex_mem_we;
  } ctrl_t;

  // Canonical control bundles, in the field order of ctrl_t.
  localparam ctrl_t CTRL_RUN    = 6'b110101;  // free-running pipeline
  localparam ctrl_t CTRL_RESET  = 6'b001111;  // hold PC, flush IF/ID, NOP into ID/EX
  localparam ctrl_t CTRL_FREEZE = 6'b000000;  // nothing moves while memory is busy
  localparam ctrl_t CTRL_FLUSH  = 6'b111111;  // redirect: squash IF/ID and ID/EX
  localparam ctrl_t CTRL_STALL  = 6'b000111;  // hold PC and IF/ID, inject a bubble

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect
//   Combinational load-use comparator. It flags when the instruction in ID
//   reads a register that a load currently in EX will write. Loads that
//   target the zero register are ignored. The forwarding unit can reuse
//   this block.
//   Ports:
//     id_rn, id_rm         - source register indices of the ID instruction
//     id_uses_rn/rm        - the ID instruction actually reads that source
//     ex_memread, ex_rd    - EX instruction is a load, and its destination
//     lu_hazard            - a load-use dependency exists this cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  lu_hazard
);

  logic rn_match;
  logic rm_match;
  logic rd_real;

  assign rd_real   = (ex_rd != REG_ADDR_W'(XZR_IDX));
  assign rn_match  = id_uses_rn & (id_rn == ex_rd);
  assign rm_match  = id_uses_rm & (id_rm == ex_rd);
  assign lu_hazard = ex_memread & rd_real & (rn_match | rm_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It drives the
//   write-enable, flush and bubble controls of the PC, IF/ID, ID/EX and
//   EX/MEM registers.
//   Priority, highest first: reset, memory freeze, taken branch, load-use.
//   Ports:
//     clk, resetl        - clock; synchronous active-low reset
//     id_rn/id_rm, id_uses_rn/id_uses_rm
//                        - sources of the instruction in ID
//     ex_memread, ex_rd  - load in EX and its destination register
//     ex_branch_taken    - branch resolved taken in EX this cycle
//     dmem_busy          - data memory not done; the whole pipeline holds
//     pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we
//                        - pipeline-register controls, decided within the
//                          current cycle
//     stall_active       - high whenever the PC is held
//   Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit wrapping
//   counters:
//     perf_stall_cnt     - load-use bubble cycles
//     perf_flush_cnt     - branch flushes
//     perf_freeze_cnt    - dmem_busy cycles
//   All three clear on reset.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned REG_ADDR_W      = 5
) (
  input  logic                  clk,
  input  logic                  resetl,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_busy,
  output logic                  pc_we,
  output logic                  if_id_we,
  output logic                  if_id_flush,
  output logic                  id_ex_we,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_we,
  output logic                  stall_active
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_freeze_cnt
`endif
);

  // Remaining bubbles after the first one is emitted from RUN.
  localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  ctrl_t      ctrl;
  logic       lu_hazard;
  logic       lu_bubble;
  logic       flush_evt;
  logic       freeze_evt;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_uses_rn (id_uses_rn),
    .id_uses_rm (id_uses_rm),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .lu_hazard  (lu_hazard)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl       = CTRL_RUN;
    lu_bubble  = 1'b0;
    flush_evt  = 1'b0;
    freeze_evt = 1'b0;
    if (!resetl) begin
      ctrl    = CTRL_RESET;
      state_d = RUN;
      cnt_d   = 3'd0;
    end else if (dmem_busy) begin
      // State and count hold. Any branch or load-use present now is seen
      // again once memory releases the pipeline.
      ctrl       = CTRL_FREEZE;
      freeze_evt = 1'b1;
    end else if (ex_branch_taken) begin
      // A redirect makes any in-progress load-use stall pointless: the
      // dependent instruction is squashed with the rest of the wrong path.
      ctrl      = CTRL_FLUSH;
      flush_evt = 1'b1;
      state_d   = RUN;
      cnt_d     = 3'd0;
    end else if (state_q == LU_STALL) begin
      // EX only holds bubbles here, so no new hazard can appear.
      ctrl      = CTRL_STALL;
      lu_bubble = 1'b1;
      cnt_d     = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = RUN;
      end
    end else if (lu_hazard) begin
      ctrl      = CTRL_STALL;
      lu_bubble = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        state_d = LU_STALL;
        cnt_d   = LU_RELOAD;
      end
    end
  end

  // Reset is resolved in the next-state logic, so the flops just follow _d.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign pc_we        = ctrl.pc_we;
  assign if_id_we     = ctrl.if_id_we;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_we     = ctrl.id_ex_we;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign ex_mem_we    = ctrl.ex_mem_we;
  assign stall_active = ~ctrl.pc_we;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q,  perf_stall_d;
  logic [31:0] perf_flush_q,  perf_flush_d;
  logic [31:0] perf_freeze_q, perf_freeze_d;

  always_comb begin
    perf_stall_d  = perf_stall_q  + {31'd0, lu_bubble};
    perf_flush_d  = perf_flush_q  + {31'd0, flush_evt};
    perf_freeze_d = perf_freeze_q + {31'd0, freeze_evt};
    if (!resetl) begin
      perf_stall_d  = 32'd0;
      perf_flush_d  = 32'd0;
      perf_freeze_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    perf_stall_q  <= perf_stall_d;
    perf_flush_q  <= perf_flush_d;
    perf_freeze_q <= perf_freeze_d;
  end

  assign perf_stall_cnt  = perf_stall_q;
  assign perf_flush_cnt  = perf_flush_q;
  assign perf_freeze_cnt = perf_freeze_q;
`else
  // Event strobes only feed the optional counters.
  logic unused_evt;
  assign unused_evt = lu_bubble ^ flush_evt ^ freeze_evt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int unsigned LU = 2;

  // Expected output words: {pc_we, if_id_we, if_id_flush, id_ex_we,
  // id_ex_bubble, ex_mem_we, stall_active}
  localparam logic [6:0] RST = 7'b0011111;
  localparam logic [6:0] RUN = 7'b1101010;
  localparam logic [6:0] STL = 7'b0001111;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] BRF = 7'b1111110;

  typedef struct {
    logic       rstl;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rn;
    logic       urn;
    logic [4:0] rm;
    logic       urm;
    logic       br;
    logic       busy;
    logic [6:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetl;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       id_uses_rn, id_uses_rm, ex_memread, ex_branch_taken, dmem_busy;
  logic       pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, stall_active;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_freeze_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .LU_STALL_CYCLES (LU),
    .REG_ADDR_W      (5)
  ) dut (
    .clk             (clk),
    .resetl          (resetl),
    .id_rn           (id_rn),
    .id_rm           (id_rm),
    .id_uses_rn      (id_uses_rn),
    .id_uses_rm      (id_uses_rm),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .pc_we           (pc_we),
    .if_id_we        (if_id_we),
    .if_id_flush     (if_id_flush),
    .id_ex_we        (id_ex_we),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_we       (ex_mem_we),
    .stall_active    (stall_active)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_freeze_cnt (perf_freeze_cnt)
`endif
  );

  function automatic vec_t mk(logic rstl, logic mr, logic [4:0] rd, logic [4:0] rn,
                              logic urn, logic [4:0] rm, logic urm, logic br,
                              logic busy, logic [6:0] exp);
    vec_t v;
    v.rstl = rstl; v.mr = mr; v.rd = rd; v.rn = rn; v.urn = urn;
    v.rm = rm; v.urm = urm; v.br = br; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  // Shorthands for common cycles
  function automatic vec_t idle(logic [6:0] exp);
    return mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
  endfunction

  function automatic vec_t haz(logic [6:0] exp);
    return mk(1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, exp);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check the outputs
  // that result, still well before the next rising edge.
  task automatic apply(vec_t v, string nm);
    @(negedge clk);
    resetl          = v.rstl;
    ex_memread      = v.mr;
    ex_rd           = v.rd;
    id_rn           = v.rn;
    id_uses_rn      = v.urn;
    id_rm           = v.rm;
    id_uses_rm      = v.urm;
    ex_branch_taken = v.br;
    dmem_busy       = v.busy;
    #2;
    check(nm, {25'd0, pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble,
               ex_mem_we, stall_active}, {25'd0, v.exp});
  endtask

  initial begin
    resetl = 1'b0; ex_memread = 1'b0; ex_rd = '0; id_rn = '0; id_rm = '0;
    id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_branch_taken = 1'b0; dmem_busy = 1'b0;

    // Reset held three cycles; the second one also carries busy and branch.
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RST));
    vq.push_back(mk(0, 1, 5, 5, 1, 0, 0, 1, 1, RST));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RST));
    vq.push_back(idle(RUN));
    // Load-use on rn: exactly LU=2 bubbles, then run.
    vq.push_back(haz(STL));
    vq.push_back(haz(STL));
    vq.push_back(idle(RUN));
    // A load into XZR never stalls; a source that is not read never stalls.
    vq.push_back(mk(1, 1, 31, 31, 1, 31, 1, 0, 0, RUN));
    vq.push_back(mk(1, 1, 5, 5, 0, 0, 0, 0, 0, RUN));
    // Load-use on rm, then memory freeze in LU_STALL with cnt=1.
    vq.push_back(mk(1, 1, 7, 0, 0, 7, 1, 0, 0, STL));
    for (int i = 0; i < 4; i++) vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ));
    vq.push_back(idle(STL));
    vq.push_back(idle(RUN));
    // Branch coincident with a hazard: flush wins, and no stall follows.
    vq.push_back(mk(1, 1, 5, 5, 1, 0, 0, 1, 0, BRF));
    vq.push_back(idle(RUN));
    // Branch aborts a stall in progress.
    vq.push_back(haz(STL));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, BRF));
    vq.push_back(idle(RUN));
    // Busy beats branch; the branch is honoured once busy drops.
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, FRZ));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, BRF));
    vq.push_back(mk(1, 1, 5, 5, 1, 0, 0, 0, 1, FRZ));
    // Mid-stall reset returns to RUN at once.
    vq.push_back(haz(STL));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RST));
    vq.push_back(idle(RUN));

    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

    // A hazard held continuously stalls in blocks of LU, re-detected in RUN.
    for (int i = 0; i < 2 * LU; i++) apply(haz(STL), $sformatf("held_haz%0d", i));
    apply(idle(RUN), "held_haz_end");

`ifdef HAZARD_PERF_CNT_EN
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RST), "perf_rst");
    for (int h = 0; h < 3; h++) begin
      apply(haz(STL), $sformatf("perf_haz%0d", h));
      for (int k = 1; k < LU; k++) apply(idle(STL), $sformatf("perf_bub%0d_%0d", h, k));
      apply(idle(RUN), $sformatf("perf_run%0d", h));
    end
    for (int b = 0; b < 2; b++) begin
      apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, BRF), $sformatf("perf_br%0d", b));
      apply(idle(RUN), $sformatf("perf_brrun%0d", b));
    end
    for (int f = 0; f < 5; f++) apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, FRZ), $sformatf("perf_frz%0d", f));
    apply(idle(RUN), "perf_end");
    check("perf_stall_cnt", perf_stall_cnt, 32'(3 * LU));
    check("perf_flush_cnt", perf_flush_cnt, 32'd2);
    check("perf_freeze_cnt", perf_freeze_cnt, 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
